// File: rtl/onebit_pred_pair.sv
// Two-entry 1-bit branch predictor bank (A = addr 3'b001, B = addr 3'b010) with saturating stats and thrash flags.
// Optional macro HYSTERESIS_EN: a mispredict only flips the bit if the previous update also mispredicted.
module onebit_pred_entry #(
    parameter int CNT_W      = 8,
    parameter int THRASH_LIM = 3,
    parameter bit RESET_PRED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic             ot,
    input  logic             miss,
    output logic             pred,
    output logic [CNT_W-1:0] brcnt,
    output logic [CNT_W-1:0] misscnt,
    output logic             thrash
);
    localparam logic [3:0] LIM = 4'(THRASH_LIM);

    logic [3:0] streak;
    logic [3:0] streak_nxt;
`ifdef HYSTERESIS_EN
    logic pending;
`endif

    // Streak saturates at 15 so a long run never wraps back under the limit.
    always_comb begin
        streak_nxt = 4'd0;
        if (miss)
            streak_nxt = (streak == 4'hf) ? streak : streak + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred    <= RESET_PRED;
            brcnt   <= '0;
            misscnt <= '0;
            streak  <= 4'd0;
            thrash  <= 1'b0;
`ifdef HYSTERESIS_EN
            pending <= 1'b0;
`endif
        end else if (upd) begin
            if (brcnt != '1)
                brcnt <= brcnt + 1'b1;
            streak <= streak_nxt;
            thrash <= (streak_nxt >= LIM);
            if (miss) begin
                if (misscnt != '1)
                    misscnt <= misscnt + 1'b1;
`ifdef HYSTERESIS_EN
                if (pending) begin
                    pred    <= ot;
                    pending <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
`else
                pred <= ot;
`endif
            end
`ifdef HYSTERESIS_EN
            else begin
                pending <= 1'b0;
            end
`endif
        end
    end
endmodule

module onebit_pred_pair #(
    parameter int CNT_W      = 8,
    parameter int THRASH_LIM = 3,
    parameter bit RESET_PRED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    input  logic [2:0]       upd_addr,
    input  logic             otA,
    input  logic             missA,
    input  logic             otB,
    input  logic             missB,
    input  logic [2:0]       pred_addr,
    output logic             pred,
    output logic             predA,
    output logic             predB,
    output logic [CNT_W-1:0] brcntA,
    output logic [CNT_W-1:0] brcntB,
    output logic [CNT_W-1:0] misscntA,
    output logic [CNT_W-1:0] misscntB,
    output logic             thrashA,
    output logic             thrashB,
    output logic             bad_addr
);
    localparam int NUM_ENT = 2;

    logic [NUM_ENT-1:0]            upd;
    logic [NUM_ENT-1:0]            ot;
    logic [NUM_ENT-1:0]            miss;
    logic [NUM_ENT-1:0]            pbit;
    logic [NUM_ENT-1:0]            thr;
    logic [NUM_ENT-1:0][CNT_W-1:0] br;
    logic [NUM_ENT-1:0][CNT_W-1:0] mc;

    assign upd  = {upd_valid && (upd_addr == 3'b010), upd_valid && (upd_addr == 3'b001)};
    assign ot   = {otB, otA};
    assign miss = {missB, missA};

    for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
        onebit_pred_entry #(
            .CNT_W      (CNT_W),
            .THRASH_LIM (THRASH_LIM),
            .RESET_PRED (RESET_PRED)
        ) u_ent (
            .clk     (clk),
            .rst     (rst),
            .upd     (upd[i]),
            .ot      (ot[i]),
            .miss    (miss[i]),
            .pred    (pbit[i]),
            .brcnt   (br[i]),
            .misscnt (mc[i]),
            .thrash  (thr[i])
        );
    end

    assign predA    = pbit[0];
    assign predB    = pbit[1];
    assign brcntA   = br[0];
    assign brcntB   = br[1];
    assign misscntA = mc[0];
    assign misscntB = mc[1];
    assign thrashA  = thr[0];
    assign thrashB  = thr[1];

    // Lookup reads stored state only; an update in flight is not forwarded.
    always_comb begin
        pred = 1'b0;
        case (pred_addr)
            3'b001:  pred = pbit[0];
            3'b010:  pred = pbit[1];
            default: pred = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            bad_addr <= 1'b0;
        else
            bad_addr <= upd_valid && (upd_addr != 3'b001) && (upd_addr != 3'b010);
    end
endmodule
